// File: rtl/literal_emitter.sv
// Formats a value as an ASCII Verilog based literal (e.g. 8'h1a), one byte per cycle.
// Optional '_' digit grouping in fours is enabled by LITERAL_EMITTER_UNDERSCORE_EN.
module literal_emitter #(
  parameter int W_DATA = 32,
  localparam int W_LEN = $clog2(W_DATA + 1)
) (
  input  logic              i_clk,
  input  logic              resetn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [W_DATA-1:0] s_value,
  input  logic [W_LEN-1:0]  s_width,
  input  logic [1:0]        s_base,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic              m_last
);

  localparam int WX = W_LEN + 3;
  localparam logic [W_LEN-1:0] LP_WMAX = W_LEN'(W_DATA);

`ifdef LITERAL_EMITTER_UNDERSCORE_EN
  typedef enum logic [2:0] {
    S_IDLE, S_W_TENS, S_W_UNITS, S_TICK, S_BASE, S_DIGIT, S_SEP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_W_TENS, S_W_UNITS, S_TICK, S_BASE, S_DIGIT
  } state_t;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_s_ready;
  logic [W_DATA-1:0]   r_value;
  logic [W_LEN-1:0]    r_ew;
  logic [1:0]          r_base;
  logic [W_LEN-1:0]    r_cnt;

  logic                w_accept;
  logic                w_xfer;
  logic [W_LEN-1:0]    w_ew_in;
  logic [WX-1:0]       w_ewx_in;
  logic [1:0]          w_base_in;
  logic [W_DATA-1:0]   w_mask_in;
  logic [W_LEN-1:0]    w_ndig_in;
  logic [WX-1:0]       w_ewx;
  logic [WX-1:0]       w_tens;
  logic [WX-1:0]       w_units;
  logic [WX-1:0]       w_k;
  logic [3:0]          w_kmask;
  logic [WX-1:0]       w_shamt;
  logic [W_DATA+3:0]   w_val_ext;
  logic [3:0]          w_dig;
  logic [7:0]          w_dig_chr;
  logic                w_cnt_last;
  logic                w_sep_next;

  assign s_ready  = r_s_ready;
  assign w_accept = s_valid && r_s_ready;
  assign w_xfer   = m_valid && m_ready;

  // Request-side decode: clamp width, fold reserved base onto hex, size the digit run.
  assign w_ew_in   = (s_width == '0 || s_width > LP_WMAX) ? LP_WMAX : s_width;
  assign w_ewx_in  = WX'(w_ew_in);
  assign w_base_in = (s_base == 2'd3) ? 2'd2 : s_base;
  assign w_mask_in = ~({W_DATA{1'b1}} << w_ew_in);

  always_comb begin
    w_ndig_in = w_ew_in;
    case (w_base_in)
      2'd0:    w_ndig_in = w_ew_in;
      2'd1:    w_ndig_in = W_LEN'((w_ewx_in + WX'(2)) / WX'(3));
      default: w_ndig_in = W_LEN'((w_ewx_in + WX'(3)) >> 2);
    endcase
  end

  assign w_ewx   = WX'(r_ew);
  assign w_tens  = w_ewx / WX'(10);
  assign w_units = w_ewx % WX'(10);

  always_comb begin
    w_k     = WX'(4);
    w_kmask = 4'hf;
    case (r_base)
      2'd0:    begin w_k = WX'(1); w_kmask = 4'h1; end
      2'd1:    begin w_k = WX'(3); w_kmask = 4'h7; end
      default: begin w_k = WX'(4); w_kmask = 4'hf; end
    endcase
  end

  // r_cnt counts digits still to send including the current one; the value is
  // pre-masked, so the top digit naturally carries only the leftover bits.
  assign w_shamt    = WX'(r_cnt - 1'b1) * w_k;
  assign w_val_ext  = {4'b0000, r_value};
  assign w_dig      = 4'(w_val_ext >> w_shamt) & w_kmask;
  assign w_dig_chr  = (w_dig < 4'd10) ? (8'h30 + {4'b0000, w_dig})
                                      : (8'h57 + {4'b0000, w_dig});
  assign w_cnt_last = (r_cnt == W_LEN'(1));
  assign w_sep_next = ((WX'(r_cnt - 1'b1) & WX'(3)) == '0);

  always_comb begin
    w_state_nxt = r_state;
    m_valid     = 1'b1;
    m_data      = 8'h00;
    m_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        m_valid = 1'b0;
        if (w_accept) begin
          if (s_width == '0)
            w_state_nxt = S_TICK;
          else if (w_ewx_in >= WX'(10))
            w_state_nxt = S_W_TENS;
          else
            w_state_nxt = S_W_UNITS;
        end
      end
      S_W_TENS: begin
        m_data = 8'h30 + 8'(w_tens);
        if (w_xfer) w_state_nxt = S_W_UNITS;
      end
      S_W_UNITS: begin
        m_data = 8'h30 + 8'(w_units);
        if (w_xfer) w_state_nxt = S_TICK;
      end
      S_TICK: begin
        m_data = 8'h27;
        if (w_xfer) w_state_nxt = S_BASE;
      end
      S_BASE: begin
        case (r_base)
          2'd0:    m_data = 8'h62;
          2'd1:    m_data = 8'h6f;
          default: m_data = 8'h68;
        endcase
        if (w_xfer) w_state_nxt = S_DIGIT;
      end
      S_DIGIT: begin
        m_data = w_dig_chr;
        m_last = w_cnt_last;
        if (w_xfer) begin
          if (w_cnt_last)
            w_state_nxt = S_IDLE;
`ifdef LITERAL_EMITTER_UNDERSCORE_EN
          else if (w_sep_next)
            w_state_nxt = S_SEP;
`endif
          else
            w_state_nxt = S_DIGIT;
        end
      end
`ifdef LITERAL_EMITTER_UNDERSCORE_EN
      S_SEP: begin
        m_data = 8'h5f;
        if (w_xfer) w_state_nxt = S_DIGIT;
      end
`endif
      default: begin
        m_valid     = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // s_ready is registered so it rises one cycle after reset release or the last byte.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_s_ready <= 1'b0;
      r_value   <= '0;
      r_ew      <= '0;
      r_base    <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_s_ready <= (w_state_nxt == S_IDLE);
      if (w_accept) begin
        r_value <= s_value & w_mask_in;
        r_ew    <= w_ew_in;
        r_base  <= w_base_in;
        r_cnt   <= w_ndig_in;
      end else if (r_state == S_DIGIT && w_xfer) begin
        r_cnt   <= r_cnt - 1'b1;
      end
    end
  end

endmodule
